word_to_bit_serializer: RTL and testbench



---
 rtl/word_to_bit_serializer_pkg.sv | 27 ++
 rtl/word_to_bit_serializer_parity.sv | 11 +
 rtl/word_to_bit_serializer.sv | 153 +++++++++++++++
 tb/tb_word_to_bit_serializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_to_bit_serializer_pkg.sv
// Shared types and constants for the word-to-bit serializer.
// Frame length depends on the P2S_PARITY_EN build macro.
package p2s_pkg;

    localparam int unsigned WORD_W_DEF  = 32;
    localparam int unsigned N_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } p2s_state_e;

`ifdef P2S_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int unsigned frame_bits(input int unsigned word_w,
                                               input int unsigned n_words);
        return n_words * (PARITY_EN ? word_w + 1 : word_w);
    endfunction

    localparam int unsigned FRAME_BITS = frame_bits(WORD_W_DEF, N_WORDS_DEF);

endpackage

// File: rtl/word_to_bit_serializer_parity.sv
// Even-parity bit of one word (XOR reduction); used when P2S_PARITY_EN is defined.
module p2s_word_parity #(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0] word,
    output logic              parity
);

    always_comb parity = ^word;

endmodule

// File: rtl/word_to_bit_serializer.sv
// Serializes a 4-word frame MSB-first, in0 first, with sof/eof framing and backpressure.
// Build macro P2S_PARITY_EN appends an even-parity bit after each word.
module word_to_bit_serializer
    import p2s_pkg::*;
#(
    parameter int unsigned WORD_W  = WORD_W_DEF,
    parameter int unsigned N_WORDS = N_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in0,
    input  logic [WORD_W-1:0] in1,
    input  logic [WORD_W-1:0] in2,
    input  logic [WORD_W-1:0] in3,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_sof,
    output logic              ser_eof,
    output logic              busy
);

    localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned WW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned SW = N_WORDS * WORD_W;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(N_WORDS - 1);

    p2s_state_e      state_q, state_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]   bit_q,   bit_d;
    logic [WW-1:0]   word_q,  word_d;
    logic            beat;

`ifdef P2S_PARITY_EN
    logic [N_WORDS-1:0] par_q, par_d;
    logic [N_WORDS-1:0] word_par;
    logic [WORD_W-1:0]  in_words [N_WORDS];

    always_comb begin
        in_words[0] = in0;
        in_words[1] = in1;
        in_words[2] = in2;
        in_words[3] = in3;
    end

    for (genvar g = 0; g < N_WORDS; g++) begin : g_par
        p2s_word_parity #(.WORD_W(WORD_W)) u_par (
            .word   (in_words[g]),
            .parity (word_par[g])
        );
    end
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        word_d  = word_q;
`ifdef P2S_PARITY_EN
        par_d   = par_q;
`endif
        beat    = (state_q != IDLE) && ser_ready;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = {in0, in1, in2, in3};
                    bit_d   = '0;
                    word_d  = '0;
`ifdef P2S_PARITY_EN
                    par_d   = word_par;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    shreg_d = shreg_q << 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef P2S_PARITY_EN
                        state_d = PARITY;
`else
                        if (word_q == LAST_WORD) state_d = IDLE;
                        else                     word_d  = word_q + 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef P2S_PARITY_EN
            PARITY: begin
                if (beat) begin
                    if (word_q == LAST_WORD) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
`ifdef P2S_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
`ifdef P2S_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs decode registered state only, so they hold naturally during stalls.
    always_comb begin
        in_ready  = (state_q == IDLE);
        ser_valid = (state_q != IDLE);
        busy      = (state_q != IDLE);
        ser_data  = 1'b0;
        ser_sof   = 1'b0;
        ser_eof   = 1'b0;
        if (state_q == SHIFT) begin
            ser_data = shreg_q[SW-1];
            ser_sof  = (word_q == '0) && (bit_q == '0);
`ifndef P2S_PARITY_EN
            ser_eof  = (word_q == LAST_WORD) && (bit_q == LAST_BIT);
`endif
        end
`ifdef P2S_PARITY_EN
        if (state_q == PARITY) begin
            ser_data = par_q[word_q];
            ser_eof  = (word_q == LAST_WORD);
        end
`endif
    end

endmodule

// File: tb/tb_word_to_bit_serializer.sv
// Directed bench for word_to_bit_serializer; honours P2S_PARITY_EN when defined.
module tb_word_to_bit_serializer;

`ifdef P2S_PARITY_EN
    localparam int FL = 132;
`else
    localparam int FL = 128;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in0, in1, in2, in3;
    logic        in_valid;
    logic        in_ready;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        ser_sof;
    logic        ser_eof;
    logic        busy;

    int checks = 0;
    int errors = 0;

    word_to_bit_serializer #(.WORD_W(32), .N_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_sof   (ser_sof),
        .ser_eof   (ser_eof),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame, right-aligned, first bit most significant.
    function automatic logic [131:0] expf(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
`ifdef P2S_PARITY_EN
        return {w0, ^w0, w1, ^w1, w2, ^w2, w3, ^w3};
`else
        return {4'b0, w0, w1, w2, w3};
`endif
    endfunction

    task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        in0 = w0; in1 = w1; in2 = w2; in3 = w3;
        in_valid = 1'b1;
    endtask

    // Called in the first cycle after the accept edge; returns in the cycle after the eof beat.
    task automatic capture(input int stall_at, input int stall_len,
                           output logic [131:0] acc, output int nbits,
                           output int eof_cyc, output int sof_cnt);
        logic held;
        logic done;
        int   cyc;
        acc = '0; nbits = 0; eof_cyc = -1; sof_cnt = 0; done = 1'b0; cyc = 0;
        chk("first_sof", ser_sof, 1'b1);
        chk("busy_high", busy, 1'b1);
        chk("in_ready_low", in_ready, 1'b0);
        while (!done && cyc < 400) begin
            cyc++;
            if (!ser_valid) break;
            if (nbits == stall_at && stall_len > 0) begin
                ser_ready = 1'b0;
                held = ser_data;
                for (int i = 0; i < stall_len; i++) begin
                    step();
                    cyc++;
                    chk("stall_hold", ser_data, held);
                end
                ser_ready = 1'b1;
            end
            acc = {acc[130:0], ser_data};
            if (ser_sof) begin
                sof_cnt++;
                if (nbits != 0) chk("sof_position", 132'(nbits), 132'd0);
            end
            if (ser_eof) begin
                eof_cyc = cyc;
                done = 1'b1;
            end
            nbits++;
            step();
        end
        chk("frame_done", done, 1'b1);
        chk("sof_count", 132'(sof_cnt), 132'd1);
    endtask

    logic [131:0] acc;
    int nbits, eof_cyc, sof_cnt;

    initial begin
        rst = 1'b1; ser_ready = 1'b1;
        load(32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_5678, 32'h8765_4321);

        // Reset held with in_valid high: nothing may start
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_valid", ser_valid, 1'b0);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_valid", ser_valid, 1'b0);
        chk("idle_data", ser_data, 1'b0);
        chk("idle_sof", ser_sof, 1'b0);
        chk("idle_eof", ser_eof, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // Basic frame
        load(32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        in_valid = 1'b0;
        chk("basic_first_bit", ser_data, 1'b1);
        capture(-1, 0, acc, nbits, eof_cyc, sof_cnt);
        chk("basic_len", 132'(nbits), 132'(FL));
        chk("basic_eof_cycle", 132'(eof_cyc), 132'(FL));
`ifdef P2S_PARITY_EN
        chk("basic_data", acc, {32'h8000_0001, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h1, 1'b1});
`else
        chk("basic_data", acc, 132'h0_8000_0001_0000_0000_FFFF_FFFF_0000_0001);
        chk("basic_bits32_63", acc[95:64], 32'h0);
        chk("basic_bits64_95", acc[63:32], 32'hFFFF_FFFF);
        chk("basic_last_bit", acc[0], 1'b1);
`endif
        chk("post_eof_in_ready", in_ready, 1'b1);
        chk("post_eof_valid", ser_valid, 1'b0);

`ifdef P2S_PARITY_EN
        load(32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE);
        step();
        in_valid = 1'b0;
        capture(-1, 0, acc, nbits, eof_cyc, sof_cnt);
        chk("par_len", 132'(nbits), 132'd132);
        chk("par_pos32", acc[131-32], 1'b0);
        chk("par_pos65", acc[131-65], 1'b1);
        chk("par_pos98", acc[131-98], 1'b0);
        chk("par_pos131", acc[0], 1'b1);
`endif

        // Backpressure at bit 10 for 5 cycles
        load(32'hC3C3_5A5A, 32'h0F1E_2D3C, 32'h7654_3210, 32'hFEDC_BA98);
        step();
        in_valid = 1'b0;
        capture(10, 5, acc, nbits, eof_cyc, sof_cnt);
        chk("stall_len", 132'(nbits), 132'(FL));
        chk("stall_eof_cycle", 132'(eof_cyc), 132'(FL + 5));
        chk("stall_data", acc, expf(32'hC3C3_5A5A, 32'h0F1E_2D3C, 32'h7654_3210, 32'hFEDC_BA98));

        // Back-to-back: in_valid stays high with frame B presented during frame A
        load(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hA5A5_A5A5);
        step();
        load(32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1357_9BDF);
        capture(-1, 0, acc, nbits, eof_cyc, sof_cnt);
        chk("b2b_a_data", acc, expf(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hA5A5_A5A5));
        chk("b2b_bubble_in_ready", in_ready, 1'b1);
        chk("b2b_bubble_sof", ser_sof, 1'b0);
        step();
        in_valid = 1'b0;
        capture(-1, 0, acc, nbits, eof_cyc, sof_cnt);
        chk("b2b_b_len", 132'(nbits), 132'(FL));
        chk("b2b_b_data", acc, expf(32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1357_9BDF));

        // Reset mid-frame at bit 50
        load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 50; i++) step();
        chk("pre_abort_valid", ser_valid, 1'b1);
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("abort_valid", ser_valid, 1'b0);
        chk("abort_data", ser_data, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        step();
        step();
        chk("abort_hold_valid", ser_valid, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_abort_idle", ser_valid, 1'b0);
        load(32'h4000_0000, 32'h0000_0002, 32'h8000_0000, 32'h0000_0005);
        step();
        in_valid = 1'b0;
        chk("restart_first_bit", ser_data, 1'b0);
        capture(-1, 0, acc, nbits, eof_cyc, sof_cnt);
        chk("restart_len", 132'(nbits), 132'(FL));
        chk("restart_data", acc, expf(32'h4000_0000, 32'h0000_0002, 32'h8000_0000, 32'h0000_0005));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
